// File: rtl/fifo_stream_reader.sv
// Read stage for a FIFO with a registered one-cycle read latency. It turns the FIFO's
// empty/rd_en port into a valid/ready stream through a 2-entry skid buffer, and counts delivered words.
module fifo_stream_reader #(
  parameter int data_width = 4,
  parameter int cnt_width  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [data_width-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            occupancy,
  output logic [cnt_width-1:0]  pop_count
);

  logic                  inflight;
  logic [data_width-1:0] head_q;
  logic [data_width-1:0] tail_q;
  logic [1:0]            occ_q;
  logic [cnt_width-1:0]  pop_cnt_q;
  logic                  pop;
  logic [2:0]            credit;

  assign pop       = m_valid & m_ready;
  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = head_q;
  assign occupancy = occ_q;
  assign pop_count = pop_cnt_q;

  // Slots already committed after this cycle; a pop only happens when occ_q >= 1, so this never underflows.
  assign credit     = {1'b0, occ_q} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = rst & ~fifo_empty & (credit < 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight  <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= 2'd0;
      pop_cnt_q <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) begin
        pop_cnt_q <= pop_cnt_q + {{(cnt_width-1){1'b0}}, 1'b1};
      end
      case ({inflight, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_q <= fifo_dout;
          end else begin
            tail_q <= fifo_dout;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= fifo_dout;
          end else begin
            head_q <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  // The credit rule makes a capture into a full buffer unreachable.
  overflow_check: assert property (@(posedge clk) disable iff (!rst)
    !(inflight && !pop && (occ_q == 2'd2)))
    else $error("ERROR: reader overflow %m at time %0t", $time);

endmodule
